// File: rtl/upscale.sv
// Pixel-to-number converter: sign-extend, left-shift by a per-beat amount, saturate.
// Two-stage elastic pipeline with valid/ready on both sides.
module upscale #(
    parameter int unsigned NUM_WIDTH = 33,
    parameter int unsigned IMG_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           shift,
    input  logic                 up_val,
    output logic                 up_rdy,
    input  logic [IMG_WIDTH-1:0] up_data,
    output logic                 dn_val,
    input  logic                 dn_rdy,
    output logic [NUM_WIDTH-1:0] dn_data
);

    localparam logic [NUM_WIDTH-1:0] NumMax = {1'b0, {(NUM_WIDTH-1){1'b1}}};
    localparam logic [NUM_WIDTH-1:0] NumMin = {1'b1, {(NUM_WIDTH-1){1'b0}}};

    logic                        v1_q, v1_d;
    logic                        v2_q, v2_d;
    logic signed [NUM_WIDTH-1:0] e_q, e_d;
    logic [7:0]                  sh_q, sh_d;
    logic [NUM_WIDTH-1:0]        r_q, r_d;
    logic                        adv1, adv2;
    logic signed [NUM_WIDTH-1:0] top;
    logic [NUM_WIDTH-1:0]        res;

    always_comb begin
        adv2   = ~v2_q | dn_rdy;
        adv1   = ~v1_q | adv2;
        up_rdy = adv1;
        dn_val = v2_q;
        dn_data = r_q;
    end

    // Result fits iff the bits that would be shifted out plus the new sign bit all match.
    always_comb begin
        res = '0;
        top = '0;
        if (e_q == '0) begin
            res = '0;
        end else if ({24'b0, sh_q} >= NUM_WIDTH) begin
            res = e_q[NUM_WIDTH-1] ? NumMin : NumMax;
        end else begin
            top = e_q >>> (NUM_WIDTH - 32'd1 - {24'b0, sh_q});
            if (top == '0 || top == '1) begin
                res = e_q <<< sh_q;
            end else begin
                res = e_q[NUM_WIDTH-1] ? NumMin : NumMax;
            end
        end
    end

    always_comb begin
        v1_d = v1_q;
        e_d  = e_q;
        sh_d = sh_q;
        v2_d = v2_q;
        r_d  = r_q;
        if (adv1) begin
            v1_d = up_val;
            if (up_val) begin
                e_d  = {{(NUM_WIDTH-IMG_WIDTH){up_data[IMG_WIDTH-1]}}, up_data};
                sh_d = shift;
            end
        end
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                r_d = res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            e_q  <= '0;
            sh_q <= '0;
            v2_q <= 1'b0;
            r_q  <= '0;
        end else begin
            v1_q <= v1_d;
            e_q  <= e_d;
            sh_q <= sh_d;
            v2_q <= v2_d;
            r_q  <= r_d;
        end
    end

endmodule
